// File: rtl/jtag_master_if.sv
// Command/response handshake between a host and the JTAG master engine.
interface jtag_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_type;
    logic [5:0]  cmd_len;
    logic [63:0] cmd_data;
    logic        rsp_valid;
    logic [63:0] rsp_data;

    // Host side: issues commands, observes responses.
    modport master (
        output cmd_valid, cmd_type, cmd_len, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data
    );

    // Engine side: accepts commands, returns captured TDO data.
    modport slave (
        input  cmd_valid, cmd_type, cmd_len, cmd_data,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/jtag_master.sv
// JTAG master: runs TAP reset, IR shift and DR shift sequences on a divided
// TCK. Every sequence starts and ends in Run-Test/Idle with TCK low.
module jtag_master #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic          clk,
    input  logic          rst,
    jtag_master_if.slave  bus,
    output logic          jtag_tck,
    output logic          jtag_tms,
    output logic          jtag_tdi,
    output logic          jtag_trst,
    input  logic          jtag_tdo
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        PORST,
        IDLE,
        RESET_SEQ,
        HEADER,
        SHIFT,
        TRAILER,
        DONE
    } state_t;

    state_t      state;
    state_t      next_state;

    logic [7:0]  div_cnt;
    logic        phase;        // 0 = TCK low half, 1 = TCK high half
    logic [5:0]  cnt;          // period index within the current state
    logic [5:0]  cnt_next;
    logic [1:0]  type_q;
    logic [5:0]  len_q;
    logic [63:0] data_q;
    logic [63:0] rsp_q;
    logic        por;          // reset sequence was started by rst, not by a command

    logic        active;
    logic        tick_mid;
    logic        tick_end;
    logic        accept;
    logic        period_start;
    logic        ir_next;
    logic [5:0]  hdr_last;
    logic        period_tms;
    logic        period_tdi;
    logic        period_trst;

    assign active   = (state == RESET_SEQ) || (state == HEADER) ||
                      (state == SHIFT)     || (state == TRAILER);
    assign tick_mid = active && !phase && (div_cnt == DIV_LAST);
    assign tick_end = active &&  phase && (div_cnt == DIV_LAST);
    assign accept   = (state == IDLE) && bus.cmd_valid;
    assign hdr_last = (type_q == 2'd1) ? 6'd3 : 6'd2;

    // Drive levels are loaded one edge ahead: on acceptance, on the power-on
    // kick-off, or when a TCK period ends (TCK falls on the same edge).
    assign period_start = (state == PORST) || accept || tick_end;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= PORST;
        end else begin
            state <= next_state;
        end
    end

    // Next-state selection; every sequence step advances only at a period end.
    always_comb begin
        next_state = state;
        case (state)
            PORST:     next_state = RESET_SEQ;
            IDLE: begin
                if (bus.cmd_valid) begin
                    if (bus.cmd_type == 2'd1 || bus.cmd_type == 2'd2) begin
                        next_state = HEADER;
                    end else begin
                        next_state = RESET_SEQ;
                    end
                end
            end
            RESET_SEQ: if (tick_end && cnt == 6'd5)     next_state = por ? IDLE : DONE;
            HEADER:    if (tick_end && cnt == hdr_last) next_state = SHIFT;
            SHIFT:     if (tick_end && cnt == len_q)    next_state = TRAILER;
            TRAILER:   if (tick_end && cnt == 6'd1)     next_state = DONE;
            DONE:      next_state = IDLE;
            default:   next_state = PORST;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        bus.cmd_ready = (state == IDLE);
        bus.rsp_valid = (state == DONE);
        bus.rsp_data  = rsp_q;
    end

    // TMS/TDI/TRST levels for the period about to begin.
    always_comb begin
        cnt_next    = (next_state != state) ? 6'd0 : cnt + 6'd1;
        ir_next     = (state == IDLE) ? (bus.cmd_type == 2'd1) : (type_q == 2'd1);
        period_tms  = 1'b0;
        period_tdi  = 1'b0;
        period_trst = 1'b0;
        case (next_state)
            RESET_SEQ: begin
                period_tms  = (cnt_next < 6'd5);
                period_trst = (cnt_next < 6'd5);
            end
            HEADER:  period_tms = ir_next ? (cnt_next < 6'd2) : (cnt_next == 6'd0);
            SHIFT: begin
                period_tms = (cnt_next == len_q);
                period_tdi = data_q[cnt_next];
            end
            TRAILER: period_tms = (cnt_next == 6'd0);
            default: ;
        endcase
    end

    // TCK divider: CLK_DIV cycles low, then CLK_DIV cycles high, restarting
    // cleanly whenever no sequence is running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt  <= '0;
            phase    <= 1'b0;
            jtag_tck <= 1'b0;
        end else begin
            if (!active) begin
                div_cnt <= '0;
                phase   <= 1'b0;
            end else if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                phase   <= ~phase;
            end else begin
                div_cnt <= div_cnt + 8'd1;
            end
            if (tick_mid) begin
                jtag_tck <= 1'b1;
            end else if (tick_end) begin
                jtag_tck <= 1'b0;
            end
        end
    end

    // Period counter and pin levels, updated at each period start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            jtag_tms  <= 1'b1;
            jtag_tdi  <= 1'b0;
            jtag_trst <= 1'b1;
        end else if (period_start) begin
            cnt       <= cnt_next;
            jtag_tms  <= period_tms;
            jtag_tdi  <= period_tdi;
            jtag_trst <= period_trst;
        end
    end

    // Command latch and power-on flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            type_q <= '0;
            len_q  <= '0;
            data_q <= '0;
            por    <= 1'b1;
        end else begin
            if (state == IDLE) begin
                por <= 1'b0;
            end
            if (accept) begin
                type_q <= bus.cmd_type;
                len_q  <= bus.cmd_len;
                data_q <= bus.cmd_data;
            end
        end
    end

    // TDO capture on the rising TCK edge of each shift period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_q <= '0;
        end else if (accept) begin
            rsp_q <= '0;
        end else if (tick_mid && state == SHIFT) begin
            rsp_q[cnt] <= jtag_tdo;
        end
    end

endmodule

// File: tb/tb_jtag_master.sv
// Testbench for jtag_master at CLK_DIV=2 (TCK period = 4 clk).
module tb_jtag_master;

    typedef struct {
        string       name;
        logic [1:0]  ctype;
        logic [5:0]  len;
        logic [63:0] data;
        int          mode;      // 0 loopback, 1 TDO tied high, 2 TDO tied low
        logic [63:0] exp_rsp;
        int          exp_periods;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic jtag_tck, jtag_tms, jtag_tdi, jtag_trst, jtag_tdo;
    int   tdo_mode = 0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    jtag_master_if bus ();

    jtag_master #(.CLK_DIV(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .jtag_tck  (jtag_tck),
        .jtag_tms  (jtag_tms),
        .jtag_tdi  (jtag_tdi),
        .jtag_trst (jtag_trst),
        .jtag_tdo  (jtag_tdo)
    );

    assign jtag_tdo = (tdo_mode == 0) ? jtag_tdi : (tdo_mode == 1);

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Pin activity observed at each rising TCK edge.
    bit          tms_log[$];
    bit          tdi_log[$];
    bit          trst_log[$];
    logic [63:0] rsp_seen[$];
    int          dbl_cnt = 0;
    logic        prev_v = 1'b0;

    always @(posedge jtag_tck) begin
        tms_log.push_back(jtag_tms);
        tdi_log.push_back(jtag_tdi);
        trst_log.push_back(jtag_trst);
    end

    always @(negedge clk) begin
        if (bus.rsp_valid) rsp_seen.push_back(bus.rsp_data);
        if (bus.rsp_valid && prev_v) dbl_cnt++;
        prev_v = bus.rsp_valid;
    end

    logic [63:0] exp_q[$];
    bit          exp_tms[$];
    bit          exp_tdi[$];
    vec_t        vecs[7];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] pack(input bit q[$], input int base);
        logic [127:0] v = '0;
        for (int i = base; i < q.size(); i++) begin
            if (i - base < 128) v[i - base] = q[i];
        end
        return v;
    endfunction

    // Reference TAP walk for one command.
    task automatic build_exp(input logic [1:0] ctype, input logic [5:0] len, input logic [63:0] data);
        int n;
        exp_tms.delete();
        exp_tdi.delete();
        n = int'(len) + 1;
        if (ctype == 2'd1 || ctype == 2'd2) begin
            exp_tms.push_back(1'b1);
            if (ctype == 2'd1) exp_tms.push_back(1'b1);
            exp_tms.push_back(1'b0);
            exp_tms.push_back(1'b0);
            for (int i = 0; i < exp_tms.size(); i++) exp_tdi.push_back(1'b0);
            for (int i = 0; i < n; i++) begin
                exp_tms.push_back(i == n - 1);
                exp_tdi.push_back(data[i]);
            end
            exp_tms.push_back(1'b1); exp_tdi.push_back(1'b0);
            exp_tms.push_back(1'b0); exp_tdi.push_back(1'b0);
        end else begin
            for (int i = 0; i < 6; i++) begin
                exp_tms.push_back(i < 5);
                exp_tdi.push_back(1'b0);
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pins"}, {jtag_tck, jtag_tms, jtag_tdi, jtag_trst, bus.cmd_ready, bus.rsp_valid},
              6'b010100);
        check({tag, "_rsp_data"}, bus.rsp_data, 64'd0);
    endtask

    // Release rst from a negedge and check the autonomous reset sequence.
    task automatic por_check(input string tag);
        int base, sbase, c0, t;
        base  = tms_log.size();
        sbase = rsp_seen.size();
        c0    = cyc;
        rst   = 1'b0;
        t = 0;
        while (!bus.cmd_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_ready_time"}, (cyc - c0 >= 24) && (cyc - c0 <= 26), 1'b1);
        check({tag, "_periods"}, tms_log.size() - base, 6);
        check({tag, "_tms"}, pack(tms_log, base), 6'b011111);
        check({tag, "_trst"}, pack(trst_log, base), 6'b011111);
        check({tag, "_no_rsp"}, rsp_seen.size() - sbase, 0);
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!bus.cmd_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic run_cmd(input vec_t v);
        int base, sbase, t;
        logic [63:0] exp_rsp;
        wait_ready();
        check({v.name, "_idle_pins"}, {bus.cmd_ready, jtag_tck, jtag_tms, jtag_tdi, jtag_trst}, 5'b10000);
        tdo_mode = v.mode;
        build_exp(v.ctype, v.len, v.data);
        base  = tms_log.size();
        sbase = rsp_seen.size();
        exp_q.push_back(v.exp_rsp);
        bus.cmd_valid = 1'b1;
        bus.cmd_type  = v.ctype;
        bus.cmd_len   = v.len;
        bus.cmd_data  = v.data;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = '0;
        check({v.name, "_ready_drop"}, bus.cmd_ready, 1'b0);
        t = 0;
        while (rsp_seen.size() == sbase && t < 2000) begin
            @(negedge clk);
            t++;
        end
        exp_rsp = exp_q.pop_front();
        if (rsp_seen.size() == sbase) begin
            check({v.name, "_rsp_timeout"}, 1'b0, 1'b1);
        end else begin
            check({v.name, "_rsp_data"}, rsp_seen[sbase], exp_rsp);
        end
        check({v.name, "_periods"}, tms_log.size() - base, v.exp_periods);
        check({v.name, "_tms"}, pack(tms_log, base), pack(exp_tms, 0));
        check({v.name, "_tdi"}, pack(tdi_log, base), pack(exp_tdi, 0));
        repeat (3) @(negedge clk);
        check({v.name, "_rsp_hold"}, bus.rsp_data, exp_rsp);
    endtask

    initial begin
        int t, sbase, base;
        int acc_cyc[3];
        logic [63:0] e;

        vecs[0] = '{"dr8_loop",   2'd2, 6'd7,  64'hA5,                  0, 64'hA5,                  13};
        vecs[1] = '{"ir4_high",   2'd1, 6'd3,  64'h9,                   1, 64'hF,                   10};
        vecs[2] = '{"dr64_loop",  2'd2, 6'd63, 64'hFFFF_0000_1234_5678, 0, 64'hFFFF_0000_1234_5678, 69};
        vecs[3] = '{"tap_reset",  2'd0, 6'd5,  64'h1234,                1, 64'd0,                   6};
        vecs[4] = '{"type3_rst",  2'd3, 6'd9,  64'hFF,                  1, 64'd0,                   6};
        vecs[5] = '{"dr1_low",    2'd2, 6'd0,  64'h1,                   2, 64'd0,                   6};
        vecs[6] = '{"ir6_loop",   2'd1, 6'd5,  64'h2A,                  0, 64'h2A,                  12};

        bus.cmd_valid = 1'b0;
        bus.cmd_type  = '0;
        bus.cmd_len   = '0;
        bus.cmd_data  = '0;

        repeat (3) @(negedge clk);
        check_reset_values("in_reset");
        por_check("por");

        foreach (vecs[i]) run_cmd(vecs[i]);

        // Back-to-back 1-bit DR commands with cmd_valid held high.
        wait_ready();
        tdo_mode      = 0;
        sbase         = rsp_seen.size();
        bus.cmd_type  = 2'd2;
        bus.cmd_len   = 6'd0;
        bus.cmd_data  = 64'h1;
        bus.cmd_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            t = 0;
            while (!bus.cmd_ready && t < 300) begin
                @(negedge clk);
                t++;
            end
            acc_cyc[k] = cyc;
            exp_q.push_back(64'h1);
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        t = 0;
        while (rsp_seen.size() < sbase + 3 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("b2b_rsp_count", rsp_seen.size() - sbase, 3);
        check("b2b_gap0", acc_cyc[1] - acc_cyc[0], 26);
        check("b2b_gap1", acc_cyc[2] - acc_cyc[1], 26);
        for (int k = 0; k < 3; k++) begin
            e = exp_q.pop_front();
            if (sbase + k < rsp_seen.size()) check("b2b_rsp_data", rsp_seen[sbase + k], e);
        end

        // Abort during SHIFT bit 3 of an 8-bit DR shift.
        wait_ready();
        tdo_mode      = 0;
        base          = tms_log.size();
        sbase         = rsp_seen.size();
        exp_q.push_back(64'hA5);
        bus.cmd_valid = 1'b1;
        bus.cmd_type  = 2'd2;
        bus.cmd_len   = 6'd7;
        bus.cmd_data  = 64'hA5;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        t = 0;
        while (tms_log.size() < base + 7 && t < 200) begin
            @(negedge clk);
            t++;
        end
        #2 rst = 1'b1;
        #1 check_reset_values("abort");
        void'(exp_q.pop_back());
        repeat (3) @(negedge clk);
        check("abort_no_rsp", rsp_seen.size() - sbase, 0);
        por_check("abort_por");
        run_cmd(vecs[0]);

        check("single_cycle_rsp", dbl_cnt, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jtag_master.md
JTAG_MASTER -- requirements
Module: jtag_master

Interface
REQ-001 Parameter CLK_DIV, default 4, clk cycles per TCK half-period; legal range 1..255.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 cmd_valid  input  1  command offered.
REQ-005 cmd_ready  output  1  block idle and accepting a command.
REQ-006 cmd_type  input  2  0 = TAP reset, 1 = shift IR, 2 = shift DR, 3 = treated as TAP reset.
REQ-007 cmd_len  input  6  shift length minus one (0 -> 1 bit, 63 -> 64 bits).
REQ-008 cmd_data  input  64  TDI data, LSB shifted first.
REQ-009 rsp_valid  output  1  one-cycle pulse at command completion.
REQ-010 rsp_data  output  64  captured TDO bits; bit i = i-th TDO sample, bits above length = 0.
REQ-011 jtag_tck  output  1  test clock.
REQ-012 jtag_tms  output  1  test mode select.
REQ-013 jtag_tdi  output  1  test data in.
REQ-014 jtag_trst  output  1  test reset, active-high.
REQ-015 jtag_tdo  input  1  test data out from target.

Function
REQ-016 Command accepted on a clk edge with cmd_valid && cmd_ready; type, len and data latched; cmd_ready deasserts the next cycle.
REQ-017 cmd_ready high only in IDLE; low during any sequence and during the power-on TAP reset.
REQ-018 TCK period = 2*CLK_DIV clk cycles: low half first, then high half; jtag_tck idles low.
REQ-019 TMS/TDI update in the clk cycle where TCK goes low (period start); TDO sampled in the clk cycle where TCK goes high.
REQ-020 States: PORST, IDLE, RESET_SEQ, HEADER, SHIFT, TRAILER, DONE.
REQ-021 RESET_SEQ: 5 periods TMS=1, then 1 period TMS=0 (Run-Test/Idle); jtag_trst=1 for the first 5 periods; rsp_data=0.
REQ-022 HEADER for DR: TMS 1,0,0; for IR: TMS 1,1,0,0; TDI=0.
REQ-023 SHIFT: n=cmd_len+1 periods; TDI=cmd_data[i] in period i; TMS=0 except TMS=1 on the final bit (Exit1).
REQ-024 TRAILER: TMS 1 (Update), then TMS 0 (Idle); TDI=0.
REQ-025 TDO is sampled only in SHIFT periods; sample i is written into rsp_data[i].
REQ-026 Total periods: DR = n+5, IR = n+6, reset = 6.
REQ-027 DONE: rsp_valid=1 for exactly one clk, in the cycle after the last period's high half ends; rsp_data stays valid until the next command is accepted; return to IDLE next cycle.
REQ-028 The TAP is always left in Run-Test/Idle with TCK low, TMS=0, and TDI=0 between commands.
REQ-029 cmd_valid while busy is ignored; no queueing.
REQ-030 Divider counter and bit counter wrap cleanly; no extra TCK edge at state transitions.

Reset
REQ-031 While rst=1: jtag_tck=0, jtag_tms=1, jtag_tdi=0, jtag_trst=1, cmd_ready=0, rsp_valid=0, rsp_data=0, state=PORST.
REQ-032 After rst falls, the block autonomously runs RESET_SEQ with no rsp_valid pulse, then enters IDLE with cmd_ready=1.
REQ-033 rst asserted mid-command aborts immediately to REQ-031 values; no rsp_valid; the post-reset sequence follows REQ-032.

Verification (CLK_DIV=2, period = 4 clk)
REQ-034 Release rst -> 6 TCK periods, TMS 1,1,1,1,1,0, TRST high for 20 clk, then cmd_ready=1 at 24 clk plus at most 2 clk.
REQ-035 DR, cmd_len=7, data=0xA5, TDO looped to TDI -> TMS 1,0,0,0x7 with final bit 1,1,0; 13 periods; rsp_data=0xA5; rsp_valid a single pulse.
REQ-036 IR, cmd_len=3, data=0x9, TDO tied 1 -> TMS header 1,1,0,0; 10 periods; rsp_data=0xF.
REQ-037 DR, cmd_len=63, data=0xFFFF_0000_1234_5678, loopback -> rsp_data equals data; 69 periods.
REQ-038 Assert rst during SHIFT bit 3 -> outputs match REQ-031 within the same cycle; no rsp_valid; the reset sequence runs again after release.
REQ-039 Hold cmd_valid continuously with cmd_len=0 DR commands -> back-to-back accepts, one per 6 periods + 2 clk; each rsp_valid is a single pulse.
